ssd_scan_driver: RTL and testbench

SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

---
 rtl/ssd_scan_driver.sv | 122 ++++++++++++
 tb/tb_ssd_scan_driver.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-latched data and per-slot dead time.
// Optional leading-zero blanking is enabled by defining SSD_LZ_BLANK_EN.
module ssd_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 17
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] bcd,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [7:0]              D_ssd,
    output logic [NUM_DIGITS-1:0]   ssd_ctl,
    output logic                    scan_tick
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SCAN_DIV-1:0] PRESC_MAX = '1;

    logic [SCAN_DIV-1:0]     r_presc;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_frameBcd;
    logic [NUM_DIGITS-1:0]   r_frameDp;
    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_ctl;
    logic                    r_tick;

    logic [SCAN_DIV-1:0]     w_prescNext;
    logic [IDX_W-1:0]        w_idxNext;
    logic [4*NUM_DIGITS-1:0] w_frameBcdNext;
    logic [NUM_DIGITS-1:0]   w_frameDpNext;
    logic [3:0]              w_nibble;
    logic [6:0]              w_glyph;
    logic                    w_blank;
    logic                    w_wrap;
    logic [7:0]              w_segNext;
    logic [NUM_DIGITS-1:0]   w_ctlNext;
    logic                    w_tickNext;

    // Segment patterns for a..g, active-low; anything above 9 shows "F".
    function automatic logic [6:0] decodeGlyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'd0:    g = 7'b0000001;
            4'd1:    g = 7'b1001111;
            4'd2:    g = 7'b0010010;
            4'd3:    g = 7'b0000110;
            4'd4:    g = 7'b1001100;
            4'd5:    g = 7'b0100100;
            4'd6:    g = 7'b0100000;
            4'd7:    g = 7'b0001111;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0000100;
            default: g = 7'b0111000;
        endcase
        return g;
    endfunction

    // Outputs are registered from next-state values so they line up with the slot they describe.
    always_comb begin
        w_wrap         = (r_presc == PRESC_MAX);
        w_prescNext    = r_presc + SCAN_DIV'(1);
        w_idxNext      = r_idx;
        w_frameBcdNext = r_frameBcd;
        w_frameDpNext  = r_frameDp;
        if (w_wrap) begin
            if (r_idx == LAST_IDX) begin
                w_idxNext      = '0;
                w_frameBcdNext = bcd;
                w_frameDpNext  = dp_in;
            end else begin
                w_idxNext = r_idx + IDX_W'(1);
            end
        end

        w_nibble = w_frameBcdNext[{w_idxNext, 2'b00} +: 4];
        w_glyph  = decodeGlyph(w_nibble);
`ifdef SSD_LZ_BLANK_EN
        w_blank  = (w_idxNext != '0) &&
                   ((w_frameBcdNext >> {w_idxNext, 2'b00}) == '0);
`else
        w_blank  = 1'b0;
`endif
        if (w_blank) begin
            w_glyph = '1;
        end

        w_tickNext = (w_prescNext == PRESC_MAX);
        if (w_prescNext == '0) begin
            w_segNext = 8'hFF;
            w_ctlNext = '1;
        end else begin
            w_segNext = {w_glyph, ~w_frameDpNext[w_idxNext]};
            w_ctlNext = ~(NUM_DIGITS'(1) << w_idxNext);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc    <= '0;
            r_idx      <= '0;
            r_frameBcd <= '0;
            r_frameDp  <= '0;
            r_seg      <= 8'hFF;
            r_ctl      <= '1;
            r_tick     <= 1'b0;
        end else begin
            r_presc    <= w_prescNext;
            r_idx      <= w_idxNext;
            r_frameBcd <= w_frameBcdNext;
            r_frameDp  <= w_frameDpNext;
            r_seg      <= w_segNext;
            r_ctl      <= w_ctlNext;
            r_tick     <= w_tickNext;
        end
    end

    assign D_ssd     = r_seg;
    assign ssd_ctl   = r_ctl;
    assign scan_tick = r_tick;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver (4 digits, 4-cycle slots) against a cycle-count model.
module tb_ssd_scan_driver;

    localparam int ND    = 4;
    localparam int SD    = 2;
    localparam int SLOT  = 1 << SD;
    localparam int FRAME = SLOT * ND;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bcd = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [7:0]  D_ssd;
    logic [3:0]  ssd_ctl;
    logic        scan_tick;

    int          assertCount = 0;
    int          failCount = 0;
    // Cycles since reset release; the released reset state itself is t=0.
    int          t = 0;
    logic [15:0] mBcd = 16'h0;
    logic [3:0]  mDp = 4'h0;

    always #5 clk = ~clk;

    ssd_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bcd      (bcd),
        .dp_in    (dp_in),
        .D_ssd    (D_ssd),
        .ssd_ctl  (ssd_ctl),
        .scan_tick(scan_tick)
    );

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %b, expected %b (t=%0d)", name, actual, expected, t);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] b, input logic [3:0] d);
        bcd   = b;
        dp_in = d;
    endtask

    function automatic logic [7:0] expectSeg(input int digit);
        logic [3:0] nib;
        logic [7:0] s;
        nib = mBcd[digit*4 +: 4];
        case (nib)
            4'd0:    s = 8'b00000011;
            4'd1:    s = 8'b10011111;
            4'd2:    s = 8'b00100101;
            4'd3:    s = 8'b00001101;
            4'd4:    s = 8'b10011001;
            4'd5:    s = 8'b01001001;
            4'd6:    s = 8'b01000001;
            4'd7:    s = 8'b00011111;
            4'd8:    s = 8'b00000001;
            4'd9:    s = 8'b00001001;
            default: s = 8'b01110001;
        endcase
`ifdef SSD_LZ_BLANK_EN
        if (digit > 0 && (mBcd >> (4 * digit)) == 16'h0) s[7:1] = 7'h7F;
`endif
        s[0] = ~mDp[digit];
        return s;
    endfunction

    function automatic logic [15:0] randomBcd();
        logic [15:0] v;
        for (int k = 0; k < ND; k++)
            v[k*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        return v;
    endfunction

    // Model: count cycles and latch the inputs at each frame boundary.
    always @(posedge clk) begin
        if (rst_n) begin
            t = t + 1;
            if (t % FRAME == 0) begin
                mBcd = bcd;
                mDp  = dp_in;
            end
        end
    end

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        logic [7:0] eSeg;
        logic [3:0] eCtl;
        logic       eTick;
        int         ph;
        int         idx;
        if (!rst_n) begin
            eSeg  = 8'hFF;
            eCtl  = 4'hF;
            eTick = 1'b0;
        end else begin
            ph    = t % SLOT;
            idx   = (t / SLOT) % ND;
            eTick = (ph == SLOT - 1);
            if (ph == 0) begin
                eSeg = 8'hFF;
                eCtl = 4'hF;
            end else begin
                eSeg = expectSeg(idx);
                eCtl = ~(4'b0001 << idx);
            end
        end
        checkOutput("D_ssd", D_ssd, eSeg);
        checkOutput("ssd_ctl", {4'b0, ssd_ctl}, {4'b0, eCtl});
        checkOutput("scan_tick", {7'b0, scan_tick}, {7'b0, eTick});
    end

    task automatic waitT(input int target);
        int n;
        n = 0;
        while (t != target && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (t != target) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL waitT: reached t=%0d, expected t=%0d", t, target);
        end
    endtask

    task automatic checkLit(input string name, input logic [3:0] eCtl, input logic [7:0] eSeg);
        checkOutput({name, "_ctl"}, {4'b0, ssd_ctl}, {4'b0, eCtl});
        checkOutput({name, "_seg"}, D_ssd, eSeg);
    endtask

    initial begin
        int n;
        applyStimulus(16'h1234, 4'h0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkLit("reset", 4'b1111, 8'hFF);
        checkOutput("reset_tick", {7'b0, scan_tick}, 8'h00);
        rst_n = 1'b1;

        waitT(1);  checkLit("frame1_d0", 4'b1110, 8'b00000011);
        waitT(3);  checkOutput("first_tick", {7'b0, scan_tick}, 8'h01);
        waitT(4);  checkLit("dead_slot1", 4'b1111, 8'hFF);
        waitT(17); checkLit("f2_d0", 4'b1110, 8'b10011001);
        waitT(21); checkLit("f2_d1", 4'b1101, 8'b00001101);
        waitT(25); checkLit("f2_d2", 4'b1011, 8'b00100101);
        waitT(29); checkLit("f2_d3", 4'b0111, 8'b10011111);

        waitT(37); applyStimulus(16'h9876, 4'h0);
        waitT(41); checkLit("midframe_d2", 4'b1011, 8'b00100101);
        waitT(49); checkLit("newframe_d0", 4'b1110, 8'b01000001);

        waitT(50); applyStimulus(16'h0A70, 4'b0100);
        waitT(65); checkLit("hexF_d0", 4'b1110, 8'b00000011);
        waitT(69); checkLit("hexF_d1", 4'b1101, 8'b00011111);
        waitT(73); checkLit("hexF_d2", 4'b1011, 8'b01110000);

        waitT(74); applyStimulus(16'h0050, 4'h0);
        waitT(81); checkLit("lz_d0", 4'b1110, 8'b00000011);
        waitT(85); checkLit("lz_d1", 4'b1101, 8'b01001001);
`ifdef SSD_LZ_BLANK_EN
        waitT(89); checkLit("lz_d2", 4'b1011, 8'hFF);
        waitT(93); checkLit("lz_d3", 4'b0111, 8'hFF);
`else
        waitT(89); checkLit("lz_d2", 4'b1011, 8'b00000011);
        waitT(93); checkLit("lz_d3", 4'b0111, 8'b00000011);
`endif

        for (int i = 0; i < 240; i++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 5) == 0)
                applyStimulus(randomBcd(), 4'($urandom_range(0, 15)));
        end

        n = 0;
        while (((t / SLOT) % ND) != 2 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        applyStimulus(16'h4321, 4'hF);
        rst_n = 1'b0;
        t     = 0;
        mBcd  = 16'h0;
        mDp   = 4'h0;
        #1;
        checkLit("midreset", 4'b1111, 8'hFF);
        checkOutput("midreset_tick", {7'b0, scan_tick}, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitT(1); checkLit("restart_d0", 4'b1110, 8'b00000011);
        waitT(5); checkLit("restart_d1", 4'b1101, 8'b00000011);

        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 3) == 0)
                applyStimulus(randomBcd(), 4'($urandom_range(0, 15)));
        end

        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
